// File: rtl/voice_alloc.sv
// ============================================================================
// Module      : voice_alloc
// Description : Polyphonic voice allocator. Accepts note-on / note-off events
//               over a valid/ready handshake and drives the enable and 8-bit
//               MIDI note of NUM_VOICES square-wave oscillators. Per-voice
//               saturating age counters choose the oldest voice when stealing.
// Option      : `define VOICE_STEAL_EN -> a note-on with no free voice
//               overwrites the oldest voice and pulses steal_o.
//               Undefined -> such a note-on is dropped and drop_o pulses;
//               steal_o is tied low.
// Ports       : clk_i, nrst_i          clock, async active-low reset
//               evt_valid_i/ready_o    event handshake (ready only in IDLE)
//               evt_on_i, evt_note_i   event type and MIDI note
//               panic_i                synchronous all-notes-off
//               voice_en_o/note_o      oscillator enables / notes (8b each)
//               full_o                 all voices enabled
//               drop_o, steal_o        1-cycle pulses after APPLY
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BW     = 8
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    evt_valid_i,
  output logic                    evt_ready_o,
  input  logic                    evt_on_i,
  input  logic [7:0]              evt_note_i,
  input  logic                    panic_i,
  output logic [NUM_VOICES-1:0]   voice_en_o,
  output logic [8*NUM_VOICES-1:0] voice_note_o,
  output logic                    full_o,
  output logic                    drop_o,
  output logic                    steal_o
);

  localparam int                IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_BW-1:0] C_AGE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured event
  logic              r_evt_on;
  logic [7:0]        r_evt_note;

  // Lookup results registered in LOOKUP
  logic              r_match_hit;
  logic [IDX_W-1:0]  r_match_idx;
  logic              r_free_hit;
  logic [IDX_W-1:0]  r_free_idx;

  // Voice state
  logic [NUM_VOICES-1:0] r_en;
  logic [7:0]            r_note [NUM_VOICES];
  logic [AGE_BW-1:0]     r_age  [NUM_VOICES];
  logic                  r_full;
  logic                  r_drop;

  // Lookup combinational results
  logic              w_match_hit;
  logic [IDX_W-1:0]  w_match_idx;
  logic              w_free_hit;
  logic [IDX_W-1:0]  w_free_idx;

  // Next voice state computed for APPLY
  logic [NUM_VOICES-1:0] w_en_nxt;
  logic [7:0]            w_note_nxt [NUM_VOICES];
  logic [AGE_BW-1:0]     w_age_nxt  [NUM_VOICES];
  logic                  w_drop_nxt;
  logic                  w_steal_nxt;
  logic                  w_on_apply;
  logic [IDX_W-1:0]      w_tgt;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (panic_i) begin
      // Panic wins in every state; any in-flight event is abandoned.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (evt_valid_i) w_state_nxt = ST_LOOKUP;
        ST_LOOKUP: w_state_nxt = ST_APPLY;
        ST_APPLY:  w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign evt_ready_o = (r_state == ST_IDLE);

  // --------------------------------------------------------------------------
  // Event capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_evt_on   <= 1'b0;
      r_evt_note <= '0;
    end else if (r_state == ST_IDLE && evt_valid_i) begin
      r_evt_on   <= evt_on_i;
      r_evt_note <= evt_note_i;
    end
  end

  // --------------------------------------------------------------------------
  // Lookup: matching active voice and lowest free voice. Scanning from the
  // top down lets the lowest index overwrite earlier hits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (r_en[k] && (r_note[k] == r_evt_note)) begin
        w_match_hit = 1'b1;
        w_match_idx = IDX_W'(k);
      end
      if (!r_en[k]) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_match_hit <= 1'b0;
      r_match_idx <= '0;
      r_free_hit  <= 1'b0;
      r_free_idx  <= '0;
    end else if (r_state == ST_LOOKUP) begin
      r_match_hit <= w_match_hit;
      r_match_idx <= w_match_idx;
      r_free_hit  <= w_free_hit;
      r_free_idx  <= w_free_idx;
    end
  end

`ifdef VOICE_STEAL_EN
  // --------------------------------------------------------------------------
  // Oldest voice: strict '>' while scanning upward keeps the lowest index on
  // ties. Only consulted when every voice is enabled.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]  w_old_idx;
  logic [AGE_BW-1:0] w_old_age;
  logic [IDX_W-1:0]  r_old_idx;
  logic              r_steal;

  always_comb begin
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int k = 1; k < NUM_VOICES; k++) begin
      if (r_age[k] > w_old_age) begin
        w_old_age = r_age[k];
        w_old_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_old_idx <= '0;
    end else if (r_state == ST_LOOKUP) begin
      r_old_idx <= w_old_idx;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_steal <= 1'b0;
    end else if (panic_i) begin
      r_steal <= 1'b0;
    end else begin
      r_steal <= (r_state == ST_APPLY) && w_steal_nxt;
    end
  end

  assign steal_o = r_steal;
`else
  assign steal_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // APPLY: decide the single voice that changes and the resulting state
  // --------------------------------------------------------------------------
  always_comb begin
    w_en_nxt    = r_en;
    w_note_nxt  = r_note;
    w_age_nxt   = r_age;
    w_drop_nxt  = 1'b0;
    w_steal_nxt = 1'b0;
    w_on_apply  = 1'b0;
    w_tgt       = '0;

    // Notes with bit 7 set are consumed without effect.
    if (!r_evt_note[7]) begin
      if (r_evt_on) begin
        if (r_match_hit) begin
          // Retrigger keeps the note unique: reuse the voice already playing it.
          w_on_apply = 1'b1;
          w_tgt      = r_match_idx;
        end else if (r_free_hit) begin
          w_on_apply = 1'b1;
          w_tgt      = r_free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          w_on_apply  = 1'b1;
          w_tgt       = r_old_idx;
          w_steal_nxt = 1'b1;
`else
          w_drop_nxt  = 1'b1;
`endif
        end
      end else if (r_match_hit) begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (IDX_W'(k) == r_match_idx) begin
            w_en_nxt[k]  = 1'b0;
            w_age_nxt[k] = '0;
          end
        end
      end
    end

    if (w_on_apply) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (IDX_W'(k) == w_tgt) begin
          w_en_nxt[k]   = 1'b1;
          w_note_nxt[k] = r_evt_note;
          w_age_nxt[k]  = '0;
        end else if (r_en[k] && (r_age[k] != C_AGE_MAX)) begin
          w_age_nxt[k] = r_age[k] + AGE_BW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Voice registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_en   <= '0;
      r_full <= 1'b0;
      r_drop <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        r_note[k] <= '0;
        r_age[k]  <= '0;
      end
    end else if (panic_i) begin
      // Notes are retained so a later note-off cannot match a silenced voice
      // (enables are clear), but the oscillators keep their last pitch.
      r_en   <= '0;
      r_full <= 1'b0;
      r_drop <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        r_age[k] <= '0;
      end
    end else begin
      r_drop <= 1'b0;
      if (r_state == ST_APPLY) begin
        r_en   <= w_en_nxt;
        r_note <= w_note_nxt;
        r_age  <= w_age_nxt;
        // full follows the enables it is derived from in the same cycle.
        r_full <= &w_en_nxt;
        r_drop <= w_drop_nxt;
      end
    end
  end

  assign voice_en_o = r_en;
  assign full_o     = r_full;
  assign drop_o     = r_drop;

  generate
    for (genvar gk = 0; gk < NUM_VOICES; gk++) begin : g_note_pack
      assign voice_note_o[8*gk +: 8] = r_note[gk];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_voice_alloc.sv
// ============================================================================
// Module      : tb_voice_alloc
// Description : Self-checking bench for voice_alloc. Directed scenarios plus
//               randomized events compared against a behavioural voice model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_voice_alloc;

  localparam int NV = 4;

  logic          clk_i = 1'b0;
  logic          nrst_i = 1'b0;
  logic          evt_valid_i = 1'b0;
  logic          evt_ready_o;
  logic          evt_on_i = 1'b0;
  logic [7:0]    evt_note_i = '0;
  logic          panic_i = 1'b0;
  logic [NV-1:0] voice_en_o;
  logic [8*NV-1:0] voice_note_o;
  logic          full_o;
  logic          drop_o;
  logic          steal_o;

  int n_cmp = 0;
  int n_err = 0;

  voice_alloc #(
    .NUM_VOICES (NV),
    .AGE_BW     (8)
  ) u_dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .evt_valid_i  (evt_valid_i),
    .evt_ready_o  (evt_ready_o),
    .evt_on_i     (evt_on_i),
    .evt_note_i   (evt_note_i),
    .panic_i      (panic_i),
    .voice_en_o   (voice_en_o),
    .voice_note_o (voice_note_o),
    .full_o       (full_o),
    .drop_o       (drop_o),
    .steal_o      (steal_o)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Behavioural model: voices as plain arrays, one event at a time
  // --------------------------------------------------------------------------
  bit m_en   [NV];
  int m_note [NV];
  int m_age  [NV];
  bit m_drop;
  bit m_steal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset(input bit clear_notes);
    for (int v = 0; v < NV; v++) begin
      m_en[v]  = 1'b0;
      m_age[v] = 0;
      if (clear_notes) m_note[v] = 0;
    end
  endtask

  task automatic m_event(input bit on, input int note);
    int hit;
    int tgt;
    int best;
    m_drop  = 1'b0;
    m_steal = 1'b0;
    hit = -1;
    tgt = -1;
    if (note < 128) begin
      for (int v = 0; v < NV; v++)
        if (hit < 0 && m_en[v] && m_note[v] == note) hit = v;
      if (!on) begin
        if (hit >= 0) begin
          m_en[hit]  = 1'b0;
          m_age[hit] = 0;
        end
      end else begin
        tgt = hit;
        for (int v = 0; v < NV; v++)
          if (tgt < 0 && !m_en[v]) tgt = v;
        if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
          best = -1;
          for (int v = 0; v < NV; v++)
            if (m_age[v] > best) begin
              best = m_age[v];
              tgt  = v;
            end
          m_steal = 1'b1;
`else
          m_drop = 1'b1;
`endif
        end
        if (tgt >= 0) begin
          for (int v = 0; v < NV; v++)
            if (v != tgt && m_en[v]) m_age[v] = (m_age[v] >= 255) ? 255 : m_age[v] + 1;
          m_en[tgt]   = 1'b1;
          m_note[tgt] = note;
          m_age[tgt]  = 0;
        end
      end
    end
  endtask

  function automatic logic [NV-1:0] m_en_vec();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_en[v];
    return r;
  endfunction

  function automatic logic [8*NV-1:0] m_note_vec();
    logic [8*NV-1:0] r;
    for (int v = 0; v < NV; v++) r[8*v +: 8] = 8'(m_note[v]);
    return r;
  endfunction

  task automatic check_outputs(input bit exp_drop, input bit exp_steal, input bit exp_ready);
    logic [NV-1:0] e;
    e = m_en_vec();
    chk("voice_en",   32'(voice_en_o),   32'(e));
    chk("voice_note", 32'(voice_note_o), 32'(m_note_vec()));
    chk("full",       32'(full_o),       32'(&e));
    chk("drop",       32'(drop_o),       32'(exp_drop));
    chk("steal",      32'(steal_o),      32'(exp_steal));
    chk("ready",      32'(evt_ready_o),  32'(exp_ready));
  endtask

  // --------------------------------------------------------------------------
  // Stimulus tasks; each is entered and left just after a falling edge
  // --------------------------------------------------------------------------
  task automatic send(input bit on, input logic [7:0] note);
    evt_valid_i = 1'b1;
    evt_on_i    = on;
    evt_note_i  = note;
    chk("ready_c0", 32'(evt_ready_o), 32'd1);
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    chk("ready_c1", 32'(evt_ready_o), 32'd0);
    @(negedge clk_i);
    chk("ready_c2", 32'(evt_ready_o), 32'd0);
    m_event(on, int'(note));
    @(negedge clk_i);
    check_outputs(m_drop, m_steal, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      check_outputs(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic panic_pulse();
    panic_i = 1'b1;
    @(negedge clk_i);
    panic_i = 1'b0;
    m_reset(1'b0);
    check_outputs(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    m_reset(1'b1);
    check_outputs(1'b0, 1'b0, 1'b1);
    nrst_i = 1'b1;
    idle(1);

    // Single note-on lands in voice 0 at cycle 3
    send(1'b1, 8'd60);
    chk("t1_en", 32'(voice_en_o), 32'h1);
    chk("t1_note0", 32'(voice_note_o[7:0]), 32'd60);

    // Fill all voices, then one more note-on
    send(1'b1, 8'd64);
    send(1'b1, 8'd67);
    send(1'b1, 8'd71);
    send(1'b1, 8'd72);
`ifdef VOICE_STEAL_EN
    chk("t2_steal_note0", 32'(voice_note_o[7:0]), 32'd72);
`else
    chk("t2_drop_note0", 32'(voice_note_o[7:0]), 32'd60);
`endif
    idle(1);

    // Retrigger: same note twice uses a single voice
    panic_pulse();
    send(1'b1, 8'd64);
    send(1'b1, 8'd64);
    idle(1);

    // Note-off keeps the note; unmatched note-off ignored
    panic_pulse();
    send(1'b1, 8'd60);
    send(1'b1, 8'd64);
    send(1'b0, 8'd64);
    chk("t4_en1", 32'(voice_en_o[1]), 32'd0);
    send(1'b0, 8'd50);

    // Panic while the event sits in LOOKUP
    evt_valid_i = 1'b1;
    evt_on_i    = 1'b1;
    evt_note_i  = 8'd67;
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    panic_i     = 1'b1;
    @(negedge clk_i);
    panic_i = 1'b0;
    m_reset(1'b0);
    check_outputs(1'b0, 1'b0, 1'b1);
    idle(2);

    // Out-of-range note consumed silently
    send(1'b1, 8'h80);
    send(1'b1, 8'd61);

    // Asynchronous reset while in APPLY
    evt_valid_i = 1'b1;
    evt_on_i    = 1'b1;
    evt_note_i  = 8'd62;
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    @(negedge clk_i);
    nrst_i = 1'b0;
    #1;
    m_reset(1'b1);
    check_outputs(1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    nrst_i = 1'b1;
    idle(2);

    // Age saturation: voice 0 wraps without saturation and would lose the tie
    send(1'b1, 8'd60);
    send(1'b1, 8'd64);
    send(1'b1, 8'd67);
    send(1'b1, 8'd71);
    repeat (253) send(1'b1, 8'd71);
    send(1'b1, 8'd72);
    idle(1);

    // Randomized events
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        panic_pulse();
      end else if (r < 8) begin
        send(1'($urandom_range(0, 1)), 8'(128 + $urandom_range(0, 127)));
      end else begin
        send(($urandom_range(0, 99) < 60), 8'(58 + $urandom_range(0, 9)));
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
